// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the single-ported memory arbiter.
package mem_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } arb_owner_t;

    localparam int MAX_LATENCY = 4;
    localparam int LAT_CNT_W   = $clog2(MAX_LATENCY);
    // Wide enough for the largest allowed MaxWait (15).
    localparam int STARVE_W    = 4;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction-fetch and data-access requests onto one single-ported
// memory with fixed read latency and bounded fetch starvation.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int Bits    = 64,
    parameter int Latency = 1,
    parameter int MaxWait = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req,
    input  logic [31:0]     if_addr,
    output logic            if_gnt,
    output logic            if_rvalid,
    output logic [31:0]     if_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [31:0]     d_addr,
    input  logic [Bits-1:0] d_wdata,
    output logic            d_gnt,
    output logic            d_rvalid,
    output logic [Bits-1:0] d_rdata,
    output logic            mem_en,
    output logic            mem_we,
    output logic [31:0]     mem_addr,
    output logic [Bits-1:0] mem_wdata,
    input  logic [Bits-1:0] mem_rdata,
    output logic            busy
);

    generate
        if (Bits < 32) begin : g_bad_bits
            $error("mem_port_arbiter: Bits must be at least 32");
        end
        if (Latency < 1 || Latency > MAX_LATENCY) begin : g_bad_latency
            $error("mem_port_arbiter: Latency must be in 1..4");
        end
        if (MaxWait < 1 || MaxWait > 15) begin : g_bad_maxwait
            $error("mem_port_arbiter: MaxWait must be in 1..15");
        end
    endgenerate

    localparam logic [LAT_CNT_W-1:0] LAT_RELOAD = LAT_CNT_W'(Latency - 1);
    localparam logic [STARVE_W-1:0]  STARVE_MAX = STARVE_W'(MaxWait);

    arb_state_t           r_state,      w_state_next;
    arb_owner_t           r_owner,      w_owner_next;
    logic [LAT_CNT_W-1:0] r_lat_cnt,    w_lat_cnt_next;
    logic [STARVE_W-1:0]  r_starve_cnt, w_starve_cnt_next;

    logic w_resp;
    logic w_can_issue;
    logic w_if_win;
    logic w_d_win;
    logic w_issue_read;

    // The response cycle is also an issue slot, which gives back-to-back reads.
    assign w_resp       = (r_state == WAIT) && (r_lat_cnt == '0);
    assign w_can_issue  = (r_state == IDLE) || w_resp;
    assign w_if_win     = w_can_issue && if_req && (!d_req || (r_starve_cnt == STARVE_MAX));
    assign w_d_win      = w_can_issue && d_req && !w_if_win;
    assign w_issue_read = w_if_win || (w_d_win && !d_we);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_owner      <= OWN_IF;
            r_lat_cnt    <= '0;
            r_starve_cnt <= '0;
        end else begin
            r_state      <= w_state_next;
            r_owner      <= w_owner_next;
            r_lat_cnt    <= w_lat_cnt_next;
            r_starve_cnt <= w_starve_cnt_next;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        w_state_next      = r_state;
        w_owner_next      = r_owner;
        w_lat_cnt_next    = r_lat_cnt;
        w_starve_cnt_next = r_starve_cnt;

        if (w_issue_read) begin
            w_state_next   = WAIT;
            w_lat_cnt_next = LAT_RELOAD;
            w_owner_next   = w_d_win ? OWN_D : OWN_IF;
        end else if (w_resp) begin
            w_state_next = IDLE;
        end else if (r_state == WAIT) begin
            w_lat_cnt_next = r_lat_cnt - 1'b1;
        end

        if (w_if_win) begin
            w_starve_cnt_next = '0;
        end else if (if_req && w_d_win && (r_starve_cnt != STARVE_MAX)) begin
            w_starve_cnt_next = r_starve_cnt + 1'b1;
        end
    end

    always_comb begin
        if_gnt    = w_if_win;
        d_gnt     = w_d_win;
        mem_en    = w_if_win || w_d_win;
        mem_we    = w_d_win && d_we;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_if_win) begin
            mem_addr = if_addr;
        end else if (w_d_win) begin
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end

        if_rvalid = w_resp && (r_owner == OWN_IF);
        d_rvalid  = w_resp && (r_owner == OWN_D);
        if_rdata  = if_rvalid ? mem_rdata[31:0] : '0;
        d_rdata   = d_rvalid ? mem_rdata : '0;
        busy      = (r_state == WAIT);
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances (Latency 1, 2, 3) checked every cycle
// against a cycle-number based model, plus directed literal expectations.
module tb_mem_port_arbiter;

    localparam int NI   = 3;
    localparam int MAXW = 3;
    localparam int BITS = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic            if_req    [NI];
    logic [31:0]     if_addr   [NI];
    logic            d_req     [NI];
    logic            d_we      [NI];
    logic [31:0]     d_addr    [NI];
    logic [BITS-1:0] d_wdata   [NI];
    logic [BITS-1:0] mem_rdata [NI];

    logic            if_gnt    [NI];
    logic            if_rvalid [NI];
    logic [31:0]     if_rdata  [NI];
    logic            d_gnt     [NI];
    logic            d_rvalid  [NI];
    logic [BITS-1:0] d_rdata   [NI];
    logic            mem_en    [NI];
    logic            mem_we    [NI];
    logic [31:0]     mem_addr  [NI];
    logic [BITS-1:0] mem_wdata [NI];
    logic            busy      [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        mem_port_arbiter #(
            .Bits    (BITS),
            .Latency (g + 1),
            .MaxWait (MAXW)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .if_req    (if_req[g]),
            .if_addr   (if_addr[g]),
            .if_gnt    (if_gnt[g]),
            .if_rvalid (if_rvalid[g]),
            .if_rdata  (if_rdata[g]),
            .d_req     (d_req[g]),
            .d_we      (d_we[g]),
            .d_addr    (d_addr[g]),
            .d_wdata   (d_wdata[g]),
            .d_gnt     (d_gnt[g]),
            .d_rvalid  (d_rvalid[g]),
            .d_rdata   (d_rdata[g]),
            .mem_en    (mem_en[g]),
            .mem_we    (mem_we[g]),
            .mem_addr  (mem_addr[g]),
            .mem_wdata (mem_wdata[g]),
            .mem_rdata (mem_rdata[g]),
            .busy      (busy[g])
        );
    end

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Model: cycle number at which the outstanding read responds (-1 = none).
    int m_pend   [NI];
    bit m_own_d  [NI];
    int m_starve [NI];
    bit e_if_gnt [NI];
    bit e_d_gnt  [NI];

    task automatic check(input string name, input int inst, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s inst%0d cycle %0d: got 0x%0h expected 0x%0h",
                     name, inst, cyc, act, exp);
        end
    endtask

    task automatic model_cycle();
        for (int i = 0; i < NI; i++) begin
            int  lat;
            bit  resp, can, win_if, win_d, own_d_now;
            lat = i + 1;
            if (rst) begin
                m_pend[i]   = -1;
                m_starve[i] = 0;
                m_own_d[i]  = 1'b0;
            end
            resp      = (m_pend[i] == cyc);
            can       = (m_pend[i] < 0) || resp;
            win_if    = can && if_req[i] && (!d_req[i] || (m_starve[i] == MAXW));
            win_d     = can && d_req[i] && !win_if;
            own_d_now = m_own_d[i];
            e_if_gnt[i] = win_if;
            e_d_gnt[i]  = win_d;

            check("if_gnt", i, if_gnt[i], win_if);
            check("d_gnt", i, d_gnt[i], win_d);
            check("mem_en", i, mem_en[i], win_if || win_d);
            check("mem_we", i, mem_we[i], win_d && d_we[i]);
            if (win_if)
                check("mem_addr", i, mem_addr[i], if_addr[i]);
            if (win_d)
                check("mem_addr", i, mem_addr[i], d_addr[i]);
            if (win_d && d_we[i])
                check("mem_wdata", i, mem_wdata[i], d_wdata[i]);
            check("if_rvalid", i, if_rvalid[i], resp && !own_d_now);
            check("if_rdata", i, if_rdata[i],
                  (resp && !own_d_now) ? {32'h0, mem_rdata[i][31:0]} : 64'h0);
            check("d_rvalid", i, d_rvalid[i], resp && own_d_now);
            check("d_rdata", i, d_rdata[i], (resp && own_d_now) ? mem_rdata[i] : 64'h0);
            check("busy", i, busy[i], m_pend[i] >= cyc);

            if (resp)
                m_pend[i] = -1;
            if (win_if || (win_d && !d_we[i])) begin
                m_pend[i]  = cyc + lat;
                m_own_d[i] = win_d;
            end
            if (win_if)
                m_starve[i] = 0;
            else if (if_req[i] && win_d && (m_starve[i] < MAXW))
                m_starve[i] = m_starve[i] + 1;
        end
        cyc++;
    endtask

    task automatic sample();
        @(negedge clk);
        model_cycle();
    endtask

    // Requesters drop their request once the cycle that granted it has been clocked.
    task automatic advance();
        @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            if (e_if_gnt[i]) if_req[i] = 1'b0;
            if (e_d_gnt[i])  d_req[i]  = 1'b0;
        end
    endtask

    task automatic tick();
        sample();
        advance();
    endtask

    task automatic drain();
        for (int k = 0; k < 12; k++) tick();
        for (int i = 0; i < NI; i++)
            check("drain_idle", i, {if_req[i], d_req[i], busy[i]}, 3'b000);
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < NI; i++) begin
            if_req[i] = 1'b0; if_addr[i] = '0; d_req[i] = 1'b0; d_we[i] = 1'b0;
            d_addr[i] = '0; d_wdata[i] = '0; mem_rdata[i] = '0;
            m_pend[i] = -1; m_own_d[i] = 1'b0; m_starve[i] = 0;
        end

        // Reset state
        sample();
        for (int i = 0; i < NI; i++) begin
            check("rst_busy", i, busy[i], 1'b0);
            check("rst_mem_en", i, mem_en[i], 1'b0);
            check("rst_d_rdata", i, d_rdata[i], 64'h0);
        end
        advance();
        tick();
        rst = 1'b0;

        // Single fetch, Latency 1
        for (int i = 0; i < NI; i++) begin if_req[i] = 1'b1; if_addr[i] = 32'h10; end
        sample();
        check("t1_if_gnt", 0, if_gnt[0], 1'b1);
        check("t1_mem_addr", 0, mem_addr[0], 32'h10);
        advance();
        for (int i = 0; i < NI; i++) mem_rdata[i] = 64'h0000_0000_DEAD_BEEF;
        sample();
        check("t1_if_rvalid", 0, if_rvalid[0], 1'b1);
        check("t1_if_rdata", 0, if_rdata[0], 32'hDEAD_BEEF);
        advance();
        drain();

        // Contended: data wins first, fetch next
        for (int i = 0; i < NI; i++) begin
            if_req[i] = 1'b1; if_addr[i] = 32'h50;
            d_req[i] = 1'b1; d_we[i] = 1'b0; d_addr[i] = 32'h40;
            mem_rdata[i] = 64'h1111_2222_3333_4444;
        end
        sample();
        check("t2_d_gnt", 0, d_gnt[0], 1'b1);
        check("t2_if_gnt", 0, if_gnt[0], 1'b0);
        check("t2_mem_addr", 0, mem_addr[0], 32'h40);
        check("t2_model_starve", 0, m_starve[0], 1);
        advance();
        sample();
        check("t2_if_gnt_next", 0, if_gnt[0], 1'b1);
        check("t2_mem_addr_next", 0, mem_addr[0], 32'h50);
        check("t2_d_rdata", 0, d_rdata[0], 64'h1111_2222_3333_4444);
        advance();
        drain();

        // Starvation bound: three denials, fetch wins the fourth contended issue
        for (int i = 0; i < NI; i++) begin if_req[i] = 1'b1; if_addr[i] = 32'h80; end
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < NI; i++) begin
                d_req[i] = 1'b1; d_we[i] = 1'b0;
                d_addr[i] = (k % 2 == 1) ? 32'h108 : 32'h100;
            end
            sample();
            check("t3_if_gnt", 0, if_gnt[0], k == 3);
            check("t3_d_gnt", 0, d_gnt[0], k != 3);
            if (k == 2) check("t3_model_starve_max", 0, m_starve[0], MAXW);
            if (k == 3) check("t3_model_starve_clr", 0, m_starve[0], 0);
            advance();
        end
        drain();

        // Latency 3: data read, then a pending fetch waits for the response cycle
        for (int i = 0; i < NI; i++) begin d_req[i] = 1'b1; d_we[i] = 1'b0; d_addr[i] = 32'h200; end
        sample();
        check("t4_d_gnt", 2, d_gnt[2], 1'b1);
        check("t4_busy0", 2, busy[2], 1'b0);
        advance();
        for (int i = 0; i < NI; i++) begin if_req[i] = 1'b1; if_addr[i] = 32'h300; end
        for (int k = 1; k <= 3; k++) begin
            for (int i = 0; i < NI; i++) mem_rdata[i] = 64'hCAFE_0000_0000_0000 + 64'(k);
            sample();
            check("t4_busy", 2, busy[2], 1'b1);
            check("t4_d_rvalid", 2, d_rvalid[2], k == 3);
            check("t4_if_gnt", 2, if_gnt[2], k == 3);
            if (k == 3) check("t4_d_rdata", 2, d_rdata[2], 64'hCAFE_0000_0000_0003);
            advance();
        end
        drain();

        // Write then fetch on the next cycle
        for (int i = 0; i < NI; i++) begin
            d_req[i] = 1'b1; d_we[i] = 1'b1; d_addr[i] = 32'h20; d_wdata[i] = 64'h1234;
        end
        sample();
        check("t5_d_gnt", 0, d_gnt[0], 1'b1);
        check("t5_mem_we", 0, mem_we[0], 1'b1);
        check("t5_mem_wdata", 0, mem_wdata[0], 64'h1234);
        check("t5_mem_addr", 0, mem_addr[0], 32'h20);
        advance();
        for (int i = 0; i < NI; i++) begin if_req[i] = 1'b1; if_addr[i] = 32'h30; end
        sample();
        check("t5_if_gnt", 0, if_gnt[0], 1'b1);
        check("t5_mem_we_off", 0, mem_we[0], 1'b0);
        check("t5_no_d_rvalid", 0, d_rvalid[0], 1'b0);
        advance();
        sample();
        check("t5_no_d_rvalid_2", 0, d_rvalid[0], 1'b0);
        check("t5_if_rvalid", 0, if_rvalid[0], 1'b1);
        advance();
        drain();

        // Latency 2: reset during the outstanding read drops the response
        for (int i = 0; i < NI; i++) begin if_req[i] = 1'b1; if_addr[i] = 32'h400; end
        sample();
        check("t6_if_gnt", 1, if_gnt[1], 1'b1);
        advance();
        rst = 1'b1;
        for (int i = 0; i < NI; i++) begin if_req[i] = 1'b0; d_req[i] = 1'b0; end
        sample();
        check("t6_rst_busy", 1, busy[1], 1'b0);
        check("t6_rst_if_rvalid", 1, if_rvalid[1], 1'b0);
        advance();
        rst = 1'b0;
        sample();
        check("t6_no_if_rvalid", 1, if_rvalid[1], 1'b0);
        check("t6_no_busy", 1, busy[1], 1'b0);
        advance();
        tick();

        // Randomised traffic with occasional reset
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                rst = 1'b1;
                for (int i = 0; i < NI; i++) begin if_req[i] = 1'b0; d_req[i] = 1'b0; end
                tick();
                rst = 1'b0;
            end
            for (int i = 0; i < NI; i++) begin
                if (!if_req[i] && ($urandom_range(0, 1) == 1)) begin
                    if_req[i]  = 1'b1;
                    if_addr[i] = $urandom & 32'hFFFF_FFFC;
                end
                if (!d_req[i] && ($urandom_range(0, 2) != 0)) begin
                    d_req[i]   = 1'b1;
                    d_we[i]    = 1'($urandom_range(0, 1));
                    d_addr[i]  = $urandom;
                    d_wdata[i] = {$urandom, $urandom};
                end
                mem_rdata[i] = {$urandom, $urandom};
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported unified memory between the pipeline's instruction-fetch port and data-access port. It sits between the IF/MEM stages and the memory macro. It serialises requests, returns read data after a fixed memory latency, and bounds fetch starvation with a wait counter. The owning stage sees back-pressure through `*_gnt`.

## Interface
- Bits, 64, data-port and memory word width (≥32)
- Latency, 1, memory read latency in cycles (1..4)
- MaxWait, 3, consecutive fetch denials before fetch gets priority (1..15)

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- if_req  in  1  fetch request, held until granted
- if_addr  in  32  fetch address, stable while if_req
- if_gnt  out  1  fetch request issued to memory this cycle
- if_rvalid  out  1  if_rdata valid
- if_rdata  out  32  instruction, mem_rdata[31:0]
- d_req  in  1  data request, held until granted
- d_we  in  1  1 = write, 0 = read
- d_addr  in  32  data address
- d_wdata  in  Bits  write data
- d_gnt  out  1  data request issued this cycle
- d_rvalid  out  1  d_rdata valid (reads only)
- d_rdata  out  Bits  read data
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  32  memory address
- mem_wdata  out  Bits  memory write data
- mem_rdata  in  Bits  memory read data, valid Latency cycles after mem_en read
- busy  out  1  read outstanding

## Operation
- States: IDLE, WAIT.
  - IDLE: port free.
  - WAIT: a read is outstanding; lat_cnt counts down from Latency-1.
- Issue condition: state IDLE, or state WAIT with lat_cnt==0 (the response cycle). Issue in the response cycle gives back-to-back throughput.
- Arbitration when issue is possible:
  - Only one requester → that one wins.
  - Both requesting → data wins, unless starve_cnt==MaxWait, in which case fetch wins.
- Issue drives mem_en=1, mem_we=d_we (data) or 0 (fetch), mem_addr/mem_wdata from the winner, and the winner's gnt=1. All of these are combinational from inputs and state.
- Owner register records the winner of a read. Reads enter WAIT with lat_cnt=Latency-1. Writes complete at the issuing edge: no rvalid, port stays/returns IDLE.
- Response: in the cycle WAIT && lat_cnt==0, the owner's rvalid=1 and its rdata=mem_rdata. Then go to IDLE, or re-enter WAIT if a new read issues that cycle.
- starve_cnt:
  - Increments (saturating at MaxWait) when if_req=1, issue possible, and data wins.
  - Clears on if_gnt.
  - Holds otherwise.
- No grant when issue is impossible; requesters hold req.
- Both rdata outputs are 0 when not valid.

## Timing
- Reset values:
  - All outputs 0, rdata buses 0.
  - State IDLE, lat_cnt 0, starve_cnt 0, owner fetch.
- Read issued cycle T → rvalid at cycle T+Latency, single-cycle pulse.
- Latency=1: one read per cycle sustained.
- Latency=L: next issue no earlier than cycle T+L.
- Write issued cycle T: the next issue may occur at T+1.
- busy=1 exactly while state==WAIT.
- Reset asserted mid-WAIT: the outstanding response is dropped, no rvalid ever appears for it, and the requester must re-request.
- Simultaneous request arrival in IDLE resolves in the same cycle; there is no idle bubble.
- starve_cnt==MaxWait guarantees fetch wins the next contended issue.

## Structure
- Package `mem_arb_pkg`: `arb_state_t` {IDLE, WAIT}, `arb_owner_t` {OWN_IF, OWN_D}, and width constant for lat_cnt ($clog2 of max Latency, 2 bits).
- Single module, no sub-module: the FSM, counters and output muxes are small.
- Parameter checks (Latency, MaxWait ranges) are done with elaboration-time assertions.

## Test plan
- Reset, then if_req=1, if_addr=0x10, Latency=1, memory returns 0xDEAD_BEEF → if_gnt at T, if_rvalid at T+1, if_rdata=0xDEADBEEF.
- if_req and d_req (read 0x40) both at T, MaxWait=3 → d_gnt at T, starve_cnt=1, if_gnt at T+1.
- d_req held continuously with alternating addresses and if_req held, MaxWait=3 → fetch denied 3 times, if_gnt on the 4th contended issue, starve_cnt back to 0.
- Latency=3, data read at T → busy high T+1..T+3, d_rvalid only at T+3, pending if_req granted at T+3.
- Data write 0x20←0x1234 at T, then fetch at T+1 → no d_rvalid, mem_we=1 at T only, if_gnt at T+1.
- Latency=2, read issued T, rst pulsed at T+1 → no rvalid at T+2, all outputs 0 after reset.
